logic_led_unit: RTL and testbench

- Parametrised, clocked successor to the switch-to-LED combinational logic boards.
- Synchronises and debounces every switch input, then evaluates three functions:
  - wide OR of switch group A;
  - NAND (any-low) of switch group B;
  - a 4-input programmable function taken from a 16-bit truth-table parameter.
- Drives registered LED outputs with lamp-test, hold and change-strobe features.
- Sits between the board switch pins and the LED pins.

---
 rtl/logic_led_unit.sv | 95 +++++++++
 tb/tb_logic_led_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/logic_led_unit.sv
// rtl/logic_led_unit.sv - synchronised, debounced switch logic driving registered LEDs
module logic_led_unit #(
  parameter int          N_IN    = 4,
  parameter int          DEB_MAX = 50000,
  parameter int          DEB_W   = 16,
  parameter logic [15:0] LUT     = 16'hA5EE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] sw_a,
  input  logic [N_IN-1:0] sw_b,
  input  logic [3:0]      sw_f,
  input  logic            lt,
  input  logic            hold,
  output logic            led1,
  output logic            led2,
  output logic            led3,
  output logic            led_chg
);

  localparam int NCH = 2 * N_IN + 4;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX - 1);

  logic [NCH-1:0]            sync1_q, sync1_d;
  logic [NCH-1:0]            sync2_q, sync2_d;
  logic [NCH-1:0]            stable_q, stable_d;
  logic [NCH-1:0][DEB_W-1:0] cnt_q, cnt_d;
  logic [2:0]                led_q, led_d;
  logic                      led_chg_q, led_chg_d;

  logic [N_IN-1:0] stab_a;
  logic [N_IN-1:0] stab_b;
  logic [3:0]      stab_f;
  logic            f1, f2, f3;

  // All channels share one bit layout: sw_a in the low bits, then sw_b, then sw_f.
  assign sync1_d = {sw_f, sw_b, sw_a};
  assign sync2_d = sync1_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  assign stab_a = stable_q[N_IN-1:0];
  assign stab_b = stable_q[2*N_IN-1:N_IN];
  assign stab_f = stable_q[NCH-1:2*N_IN];

  assign f1 = |stab_a;
  assign f2 = ~&stab_b;
  assign f3 = LUT[stab_f];

  always_comb begin
    led_d = {f3, f2, f1};
    if (lt) begin
      led_d = 3'b111;
    end else if (hold) begin
      led_d = led_q;
    end
    led_chg_d = (led_d != led_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      led_q     <= '0;
      led_chg_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      led_chg_q <= led_chg_d;
    end
  end

  assign led1    = led_q[0];
  assign led2    = led_q[1];
  assign led3    = led_q[2];
  assign led_chg = led_chg_q;

endmodule

// File: tb/tb_logic_led_unit.sv
// tb/tb_logic_led_unit.sv - directed self-checking bench for logic_led_unit
module tb_logic_led_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw_a, sw_b;
  logic [3:0] sw_f;
  logic       lt, hold;
  logic       led1, led2, led3, led_chg;

  int n_checks = 0;
  int n_errors = 0;

  int lut_exp [16] = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  logic_led_unit #(
    .N_IN   (3),
    .DEB_MAX(4),
    .DEB_W  (4),
    .LUT    (16'hA5EE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_a   (sw_a),
    .sw_b   (sw_b),
    .sw_f   (sw_f),
    .lt     (lt),
    .hold   (hold),
    .led1   (led1),
    .led2   (led2),
    .led3   (led3),
    .led_chg(led_chg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    sw_a  = '0;
    sw_b  = '0;
    sw_f  = '0;
    lt    = 1'b0;
    hold  = 1'b0;

    // reset state
    #23;
    check("rst_leds", {led3, led2, led1, led_chg}, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("post_rst_leds", {led3, led2, led1}, 3'b010);
    check("post_rst_chg", led_chg, 1);
    tick();
    check("post_rst_chg_drop", led_chg, 0);

    // latency of a new sw_a level
    sw_a = 3'b010;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("lat_led1_early", led1, 0);
      check("lat_chg_early", led_chg, 0);
    end
    tick();
    check("lat_led1_rise", led1, 1);
    check("lat_chg_pulse", led_chg, 1);
    tick();
    check("lat_chg_end", led_chg, 0);
    check("lat_led1_hold", led1, 1);

    // return to 0, then a 3-cycle glitch must be rejected
    sw_a = 3'b000;
    ticks(10);
    check("a_clear_led1", led1, 0);
    sw_a = 3'b001;
    ticks(3);
    sw_a = 3'b000;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("glitch_led1", led1, 0);
      check("glitch_chg", led_chg, 0);
    end

    // truth-table sweep
    for (int v = 0; v < 16; v++) begin
      sw_f = 4'(v);
      ticks(10);
      check($sformatf("lut_%0d", v), led3, 32'(lut_exp[v]));
    end
    sw_f = 4'd0;
    ticks(10);
    check("lut_back0", led3, 0);

    sw_b = 3'b111;
    ticks(10);
    check("nand_all_high", led2, 0);
    sw_b = 3'b011;
    ticks(10);
    check("nand_one_low", led2, 1);
    sw_b = 3'b111;
    ticks(10);
    check("nand_all_high2", led2, 0);

    // hold freezes LEDs while debouncers keep running
    hold = 1'b1;
    sw_a = 3'b100;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_led1", led1, 0);
      check("hold_chg", led_chg, 0);
    end
    hold = 1'b0;
    tick();
    check("hold_release_led1", led1, 1);
    check("hold_release_chg", led_chg, 1);
    tick();
    check("hold_release_chg_end", led_chg, 0);
    hold = 1'b1;
    tick();
    hold = 1'b0;
    tick();
    check("hold_nochange_chg", led_chg, 0);

    // lamp test overrides hold
    lt   = 1'b1;
    hold = 1'b1;
    tick();
    check("lt_leds", {led3, led2, led1}, 3'b111);
    check("lt_chg", led_chg, 1);
    lt   = 1'b0;
    hold = 1'b0;
    tick();
    check("lt_release_leds", {led3, led2, led1}, 3'b001);
    check("lt_release_chg", led_chg, 1);

    // reset mid-debounce discards the partial count
    sw_a = 3'b000;
    sw_b = 3'b000;
    ticks(10);
    check("pre_abort_led1", led1, 0);
    sw_a = 3'b001;
    ticks(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async_leds", {led3, led2, led1, led_chg}, 4'b0000);
    #3;
    rst_n = 1'b1;
    tick();
    check("abort_first_leds", {led3, led2, led1}, 3'b010);
    check("abort_first_chg", led_chg, 1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      check("abort_led1_early", led1, 0);
    end
    tick();
    check("abort_led1_rise", led1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
